// File: rtl/ibex_l2_rf_pkg.sv
// rtl/ibex_l2_rf_pkg.sv - shared types for the L2 register-file save/restore sequencer
package ibex_l2_rf_pkg;

    localparam int L2AddrW = 5;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SAVE    = 2'd1,
        S_RESTORE = 2'd2,
        S_DONE    = 2'd3
    } l2_seq_state_e;

    typedef enum logic {
        L2_SAVE    = 1'b0,
        L2_RESTORE = 1'b1
    } l2_seq_op_e;

endpackage

// File: rtl/ibex_l2_rf_sequencer.sv
// rtl/ibex_l2_rf_sequencer.sv - streams words into or out of the L2 register file over an address range
module ibex_l2_rf_sequencer
    import ibex_l2_rf_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int NumWords  = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_op_i,
    input  logic [L2AddrW-1:0]   cmd_first_i,
    input  logic [L2AddrW-1:0]   cmd_last_i,
    input  logic                 abort_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [DataWidth-1:0] in_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DataWidth-1:0] out_data_o,
    output logic [L2AddrW-1:0]   rf_addr_o,
    output logic [DataWidth-1:0] rf_wdata_o,
    output logic                 rf_we_o,
    input  logic [DataWidth-1:0] rf_rdata_i,
    output logic                 done_o,
    output logic                 busy_o
);

    localparam logic [L2AddrW-1:0] MaxAddr = L2AddrW'(NumWords - 1);
    localparam logic [L2AddrW-1:0] MinAddr = L2AddrW'(1);

    l2_seq_state_e      state;
    logic [L2AddrW-1:0] ptr;
    logic [L2AddrW-1:0] last;
    logic [L2AddrW-1:0] first_eff;
    logic [L2AddrW-1:0] last_eff;

    // Word 0 is the hardwired zero register, so ranges start at 1 at the earliest.
    assign first_eff = (cmd_first_i == '0) ? MinAddr : cmd_first_i;
    assign last_eff  = (cmd_last_i > MaxAddr) ? MaxAddr : cmd_last_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_IDLE;
            ptr   <= MinAddr;
            last  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        ptr  <= first_eff;
                        last <= last_eff;
                        if (first_eff > last_eff) begin
                            state <= S_DONE;
                        end else if (l2_seq_op_e'(cmd_op_i) == L2_RESTORE) begin
                            state <= S_RESTORE;
                        end else begin
                            state <= S_SAVE;
                        end
                    end
                end
                S_SAVE, S_RESTORE: begin
                    // ptr stops at last, so it can never wrap past the top word.
                    if ((state == S_SAVE) ? in_valid_i : out_ready_i) begin
                        if (ptr == last) begin
                            state <= S_DONE;
                        end else begin
                            ptr <= ptr + MinAddr;
                        end
                    end
                    if (abort_i) begin
                        state <= S_IDLE;
                        ptr   <= MinAddr;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    ptr   <= MinAddr;
                end
                default: begin
                    state <= S_IDLE;
                    ptr   <= MinAddr;
                end
            endcase
        end
    end

    // cmd_ready stays low while reset is held so no command is seen mid-reset.
    assign cmd_ready_o = (state == S_IDLE) & ~rst_i;
    assign busy_o      = (state != S_IDLE);
    assign done_o      = (state == S_DONE);
    assign in_ready_o  = (state == S_SAVE);
    assign out_valid_o = (state == S_RESTORE);
    assign rf_we_o     = in_ready_o & in_valid_i & (ptr != '0);
    assign rf_addr_o   = ptr;
    assign rf_wdata_o  = in_data_i;
    assign out_data_o  = rf_rdata_i;

endmodule

// File: tb/tb_ibex_l2_rf_sequencer.sv
// tb/tb_ibex_l2_rf_sequencer.sv - directed vector bench for the L2 register-file sequencer
module tb_ibex_l2_rf_sequencer;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_op;
    logic [4:0]  cmd_first;
    logic [4:0]  cmd_last;
    logic        abort;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wdata;
    logic        rf_we;
    logic [31:0] rf_rdata;
    logic        done;
    logic        busy;

    logic        fill;
    logic [31:0] rf_mem [32];
    logic [31:0] exp_rf [32];
    int          errors = 0;
    int          checks = 0;

    ibex_l2_rf_sequencer #(.DataWidth(32), .NumWords(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_op_i    (cmd_op),
        .cmd_first_i (cmd_first),
        .cmd_last_i  (cmd_last),
        .abort_i     (abort),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .rf_addr_o   (rf_addr),
        .rf_wdata_o  (rf_wdata),
        .rf_we_o     (rf_we),
        .rf_rdata_i  (rf_rdata),
        .done_o      (done),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flip-flop register file, not cleared by reset.
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= 32'hDEAD0000 | 32'(i);
        end else if (rf_we) begin
            rf_mem[rf_addr] <= rf_wdata;
        end
    end
    assign rf_rdata = rf_mem[rf_addr];

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (rf_we && rf_addr == 5'd0) begin
                errors++;
                $display("FAIL we_addr0: rf_we=%b rf_addr=%0d required no write to 0", rf_we, rf_addr);
            end
            checks++;
            if (rf_we && out_valid) begin
                errors++;
                $display("FAIL we_and_out_valid: rf_we=%b out_valid=%b required not both", rf_we, out_valid);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Entry and exit point: 1 time unit after a rising edge.
    task automatic run_cmd(input bit op, input logic [4:0] first, input logic [4:0] last,
                           input logic [31:0] base, input bit gaps,
                           output int nwords, output int ndone, output int lat);
        int  a;
        bit  accepted;
        bit  stalled;
        logic [31:0] held;
        nwords = 0; ndone = 0; lat = -1; stalled = 0; held = '0;
        a = (first == 5'd0) ? 1 : int'(first);
        cmd_valid = 1'b1; cmd_op = op; cmd_first = first; cmd_last = last;
        accepted = 1'b0;
        for (int t = 0; t < 20 && !accepted; t++) begin
            #1;
            accepted = cmd_ready;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        if (!accepted) begin
            check("accept_timeout", 32'd0, 32'd1);
            return;
        end
        for (int t = 0; t < 400; t++) begin
            in_valid  = gaps ? ($urandom_range(3) != 0) : 1'b1;
            in_data   = base + 32'(a);
            out_ready = gaps ? ($urandom_range(2) != 0) : 1'b1;
            #1;
            if (done) begin
                ndone++;
                lat = t;
                break;
            end
            if (stalled) check("restore_stable", out_data, held);
            stalled = out_valid && !out_ready;
            held    = out_data;
            if (rf_we) begin
                check("save_addr", 32'(rf_addr), 32'(a));
                exp_rf[a[4:0]] = in_data;
                nwords++; a++;
            end
            if (out_valid && out_ready) begin
                check("restore_data", out_data, exp_rf[a[4:0]]);
                nwords++; a++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        check("post_done_busy", 32'(busy), 32'd0);
        check("post_done_pulse", 32'(done), 32'd0);
    endtask

    typedef struct {
        bit          op;
        logic [4:0]  first;
        logic [4:0]  last;
        logic [31:0] base;
        bit          gaps;
        int          exp_words;
    } vec_t;

    typedef struct {
        logic cmd_ready;
        logic busy;
        logic done;
    } b2b_t;

    initial begin
        vec_t vt[7];
        b2b_t bb[9];
        int nw, nd, lat, hs;

        vt[0] = '{1'b0, 5'd1,  5'd31, 32'hA0000000, 1'b1, 31};
        vt[1] = '{1'b1, 5'd1,  5'd31, 32'h00000000, 1'b1, 31};
        vt[2] = '{1'b0, 5'd0,  5'd3,  32'hB0000000, 1'b0, 3};
        vt[3] = '{1'b0, 5'd9,  5'd5,  32'hC0000000, 1'b0, 0};
        vt[4] = '{1'b1, 5'd9,  5'd5,  32'h00000000, 1'b0, 0};
        vt[5] = '{1'b1, 5'd2,  5'd2,  32'h00000000, 1'b1, 1};
        vt[6] = '{1'b0, 5'd31, 5'd31, 32'hD0000000, 1'b1, 1};

        bb[0] = '{1'b1, 1'b0, 1'b0};
        bb[1] = '{1'b0, 1'b1, 1'b0};
        bb[2] = '{1'b0, 1'b1, 1'b0};
        bb[3] = '{1'b0, 1'b1, 1'b1};
        bb[4] = '{1'b1, 1'b0, 1'b0};
        bb[5] = '{1'b0, 1'b1, 1'b0};
        bb[6] = '{1'b0, 1'b1, 1'b0};
        bb[7] = '{1'b0, 1'b1, 1'b1};
        bb[8] = '{1'b1, 1'b0, 1'b0};

        for (int i = 0; i < 32; i++) exp_rf[i] = 32'hDEAD0000 | 32'(i);

        rst = 1'b1; fill = 1'b1;
        cmd_valid = 0; cmd_op = 0; cmd_first = 0; cmd_last = 0; abort = 0;
        in_valid = 0; in_data = 0; out_ready = 0;
        @(posedge clk); #1;
        fill = 1'b0;
        in_data = 32'h12345678;
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_done",      32'(done),      32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_rf_we",     32'(rf_we),     32'd0);
        check("rst_rf_addr",   32'(rf_addr),   32'd1);
        check("rst_rf_wdata",  rf_wdata,       32'h12345678);
        check("rst_out_data",  out_data,       32'hDEAD0001);
        rst = 1'b0;
        #1;
        check("rel_cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;

        for (int v = 0; v < 7; v++) begin
            run_cmd(vt[v].op, vt[v].first, vt[v].last, vt[v].base, vt[v].gaps, nw, nd, lat);
            check($sformatf("vec%0d_words", v), 32'(nw), 32'(vt[v].exp_words));
            check($sformatf("vec%0d_done", v), 32'(nd), 32'd1);
            if (vt[v].exp_words == 0) check($sformatf("vec%0d_latency", v), 32'(lat), 32'd0);
        end
        for (int i = 0; i < 32; i++) check($sformatf("rf_word%0d", i), rf_mem[i], exp_rf[i]);

        // Abort together with the third RESTORE handshake.
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_first = 5'd1; cmd_last = 5'd8;
        #1;
        check("abort_accept", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        hs = 0;
        for (int t = 0; t < 20; t++) begin
            out_ready = 1'b1;
            abort = (hs == 2);
            #1;
            if (out_valid) begin
                check("abort_data", out_data, exp_rf[hs + 1]);
                hs++;
            end
            @(posedge clk); #1;
            if (abort) break;
        end
        abort = 1'b0; out_ready = 1'b0;
        #1;
        check("abort_words", 32'(hs), 32'd3);
        check("abort_busy",  32'(busy), 32'd0);
        check("abort_done",  32'(done), 32'd0);
        check("abort_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        check("abort_done_later", 32'(done), 32'd0);

        // Asynchronous reset after four of ten SAVE words.
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_first = 5'd1; cmd_last = 5'd10;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            in_valid = 1'b1; in_data = 32'hE0000000 + 32'(k);
            #1;
            check("rst_mid_we", 32'(rf_we), 32'd1);
            exp_rf[k] = in_data;
            @(posedge clk); #1;
        end
        in_valid = 1'b1; in_data = 32'hE0000005;
        rst = 1'b1;
        #1;
        check("rst_mid_we_off",   32'(rf_we),     32'd0);
        check("rst_mid_busy",     32'(busy),      32'd0);
        check("rst_mid_in_ready", 32'(in_ready),  32'd0);
        check("rst_mid_addr",     32'(rf_addr),   32'd1);
        check("rst_mid_ready",    32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("rst_mid_release", 32'(cmd_ready), 32'd1);
        check("rst_mid_done",    32'(done),      32'd0);
        @(posedge clk); #1;
        for (int i = 1; i <= 5; i++) check($sformatf("rst_keep%0d", i), rf_mem[i], exp_rf[i]);

        // cmd_valid held high across two back-to-back RESTORE 3..4 commands.
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_first = 5'd3; cmd_last = 5'd4; out_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if (c == 5) cmd_valid = 1'b0;
            #1;
            check($sformatf("b2b%0d_ready", c), 32'(cmd_ready), 32'(bb[c].cmd_ready));
            check($sformatf("b2b%0d_busy", c),  32'(busy),      32'(bb[c].busy));
            check($sformatf("b2b%0d_done", c),  32'(done),      32'(bb[c].done));
            @(posedge clk); #1;
        end
        out_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ibex_l2_rf_sequencer.md
IBEX_L2_RF_SEQUENCER -- requirements
Module: ibex_l2_rf_sequencer

Interface
REQ-001 Parameter DataWidth, default 32, SHALL set the word width of the data and register-file ports.
REQ-002 Parameter NumWords, default 32, SHALL set the register-file depth; the address width is 5 bits and word 0 is never accessed.
REQ-003 clk_i  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_i  in  1  SHALL be the reset: asynchronous, active-high.
REQ-005 cmd_valid_i/cmd_ready_o  in/out  1/1  SHALL form the command handshake.
REQ-006 cmd_op_i  in  1  SHALL select the operation: 0 = SAVE (stream into the register file), 1 = RESTORE (stream out of it).
REQ-007 cmd_first_i/cmd_last_i  in  5/5  SHALL give the inclusive word-address range.
REQ-008 abort_i  in  1  SHALL be a synchronous abort of the active command.
REQ-009 in_valid_i/in_ready_o/in_data_i  in/out/in  1/1/DataWidth  SHALL be the SAVE input stream.
REQ-010 out_valid_o/out_ready_i/out_data_o  out/in/out  1/1/DataWidth  SHALL be the RESTORE output stream.
REQ-011 rf_addr_o/rf_wdata_o/rf_we_o  out/out/out  5/DataWidth/1  SHALL drive the register-file port.
REQ-012 rf_rdata_i  in  DataWidth  SHALL be the register-file read data, combinational from rf_addr_o.
REQ-013 done_o  out  1  SHALL be a one-cycle pulse when a command completes.
REQ-014 busy_o  out  1  SHALL be high whenever state != IDLE.

Function
REQ-015 The FSM SHALL have four states: IDLE, SAVE, RESTORE and DONE.
REQ-016 cmd_ready_o SHALL be 1 only in IDLE; a command is accepted on cmd_valid_i & cmd_ready_o.
REQ-017 On acceptance: ptr <= max(cmd_first_i, 1) and last <= cmd_last_i.
- Next state is SAVE or RESTORE per cmd_op_i.
- If max(first, 1) > last, next state is DONE (zero-length command, no register-file access).
REQ-018 SAVE datapath:
- in_ready_o = 1; rf_we_o = in_valid_i; rf_addr_o = ptr; rf_wdata_o = in_data_i.
- Each handshake writes one word and increments ptr.
REQ-019 RESTORE datapath:
- out_valid_o = 1; rf_addr_o = ptr; out_data_o = rf_rdata_i (zero-cycle read latency).
- ptr increments on out_ready_i.
- Data SHALL stay stable while out_valid_o & !out_ready_i.
REQ-020 When the transfer at ptr == last completes, the next state SHALL be DONE.
- ptr SHALL never wrap past 31; last == 31 terminates normally.
REQ-021 DONE SHALL assert done_o for exactly one cycle, then go to IDLE; a command presented in DONE is not accepted until IDLE.
REQ-022 abort_i in SAVE or RESTORE SHALL force IDLE next cycle with no done_o pulse.
- A handshake occurring in the same cycle as abort_i SHALL still complete (the write happens / the word is consumed).
- abort_i is ignored in IDLE and DONE.
REQ-023 Outside SAVE, rf_we_o and in_ready_o SHALL be 0; outside RESTORE, out_valid_o SHALL be 0.
REQ-024 rf_we_o SHALL never be 1 with rf_addr_o == 0.

Reset
REQ-025 rst_i high SHALL immediately force IDLE, with ptr = 1, last = 0 and all outputs 0 except cmd_ready_o = 1 once reset is released.
- rf_addr_o = 1 and rf_wdata_o/out_data_o follow their inputs.
REQ-026 Reset mid-command SHALL discard the command with no done_o pulse; register-file contents already written are kept.

Structure
REQ-027 A shared package ibex_l2_rf_pkg SHALL hold:
- the state enum l2_seq_state_e;
- the op enum l2_seq_op_e (L2_SAVE = 0, L2_RESTORE = 1);
- the localparam L2AddrW = 5.
REQ-028 The block SHALL be a single module with no sub-modules; a bench instantiates it against the flip-flop L2 register file.

Verification
REQ-029 SAVE first = 1, last = 31, 31 words 0xA0000001..0xA000001F with in_valid gaps, then RESTORE same range with random out_ready_i -> identical sequence out; done_o pulses once per command.
REQ-030 SAVE first = 0, last = 3 -> writes only addresses 1..3 and rf_we_o never with address 0.
REQ-031 Command first = 9, last = 5 -> DONE the next cycle, done_o 1 cycle, zero rf_we_o / out_valid_o.
REQ-032 RESTORE 1..8 with abort_i asserted together with the 3rd handshake -> 3 words out, IDLE next cycle, no done_o.
REQ-033 rst_i asserted asynchronously mid-SAVE after 4 of 10 words -> outputs reset immediately; addresses 1..4 retain data, address 5 unchanged.
REQ-034 Back-to-back cmd_valid_i held high -> second command accepted only after the DONE→IDLE cycle; cmd_ready_o low throughout busy_o.
